// File: rtl/d2_5_pkg.sv
// d2_5_pkg: 2-of-5 code table, FSM encoding and default error nibble
package d2_5_pkg;
  localparam logic [3:0] ERR_NIB_DEF = 4'hE;
  localparam logic [4:0] CODE_0 = 5'b01100;
  localparam logic [4:0] CODE_1 = 5'b11000;
  localparam logic [4:0] CODE_2 = 5'b10100;
  localparam logic [4:0] CODE_3 = 5'b10010;
  localparam logic [4:0] CODE_4 = 5'b01010;
  localparam logic [4:0] CODE_5 = 5'b00110;
  localparam logic [4:0] CODE_6 = 5'b10001;
  localparam logic [4:0] CODE_7 = 5'b01001;
  localparam logic [4:0] CODE_8 = 5'b00101;
  localparam logic [4:0] CODE_9 = 5'b00011;
  localparam logic [9:0][4:0] CODES = {CODE_9, CODE_8, CODE_7, CODE_6, CODE_5,
                                       CODE_4, CODE_3, CODE_2, CODE_1, CODE_0};
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_e;
endpackage

// File: rtl/d2_5_frame_dec_if.sv
// d2_5_frame_dec_if: serial input and frame result handshake bundle
interface d2_5_frame_dec_if #(parameter int NDIG = 4);
  logic in_valid, in_bit, in_sync, in_ready;
  logic out_valid, out_ready, frame_abort;
  logic [4*NDIG-1:0] out_bcd;
  logic [NDIG-1:0] out_err;
  modport master(output in_valid, in_bit, in_sync, out_ready,
                 input in_ready, out_valid, out_bcd, out_err, frame_abort);
  modport slave(input in_valid, in_bit, in_sync, out_ready,
                output in_ready, out_valid, out_bcd, out_err, frame_abort);
endinterface

// File: rtl/d2_5_digit_dec.sv
// d2_5_digit_dec: combinational 2-of-5 code to BCD nibble lookup
module d2_5_digit_dec
  import d2_5_pkg::*;
#(parameter logic [3:0] ERR_NIB = ERR_NIB_DEF)
(
  input  logic [4:0] code_i,
  output logic [3:0] nib_o,
  output logic       err_o
);
  always_comb begin
    nib_o = ERR_NIB;
    err_o = 1'b1;
    for (int i = 0; i < 10; i++)
      if (code_i == CODES[i]) begin
        nib_o = 4'(i);
        err_o = 1'b0;
      end
  end
endmodule

// File: rtl/d2_5_frame_dec.sv
// d2_5_frame_dec: serial 2-of-5 frame collector and decoder with held result
module d2_5_frame_dec
  import d2_5_pkg::*;
#(
  parameter int         NDIG      = 4,
  parameter logic [3:0] ERR_NIB   = ERR_NIB_DEF,
  parameter bit         LSB_FIRST = 1'b0
)
(
  input logic clk,
  input logic rst,
  d2_5_frame_dec_if.slave bus
);
  state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d, dig_cnt_q, dig_cnt_d, bc, dc;
  logic [4:0] sh_q, sh_d, shb;
  logic [4*NDIG-1:0] acc_q, acc_d, bcd_q, bcd_d;
  logic [NDIG-1:0] aerr_q, aerr_d, err_q, err_d;
  logic valid_q, abort_q, abort_d, take, restart, upd, dig_done, last, nerr;
  logic [3:0] nib;

  d2_5_digit_dec #(.ERR_NIB(ERR_NIB)) u_dec (.code_i(sh_d), .nib_o(nib), .err_o(nerr));

  // a sync bit restarts collection from zeroed counters, in IDLE or mid-frame
  always_comb begin
    take      = bus.in_valid && state_q != HOLD;
    restart   = take && bus.in_sync;
    upd       = take && (state_q == SHIFT || bus.in_sync);
    bc        = restart ? '0 : bit_cnt_q;
    dc        = restart ? '0 : dig_cnt_q;
    shb       = restart ? '0 : sh_q;
    sh_d      = !upd ? sh_q : LSB_FIRST ? {bus.in_bit, shb[4:1]} : {shb[3:0], bus.in_bit};
    dig_done  = upd && bc == 3'd4;
    last      = dig_done && dc == 3'(NDIG-1);
    bit_cnt_d = !upd ? bit_cnt_q : dig_done ? '0 : bc + 3'd1;
    dig_cnt_d = !upd ? dig_cnt_q : dc + {2'b0, dig_done};
    acc_d     = restart ? '0 : acc_q;
    aerr_d    = restart ? '0 : aerr_q;
    for (int i = 0; i < NDIG; i++)
      if (dig_done && dc == 3'(NDIG-1-i)) begin
        acc_d[4*i +: 4] = nib;
        aerr_d[i]       = nerr;
      end
    bcd_d   = last ? acc_d : bcd_q;
    err_d   = last ? aerr_d : err_q;
    abort_d = restart && state_q == SHIFT;
    state_d = last ? HOLD : restart ? SHIFT :
              (state_q == HOLD && valid_q && bus.out_ready) ? IDLE : state_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      dig_cnt_q <= '0;
      sh_q      <= '0;
      acc_q     <= '0;
      aerr_q    <= '0;
      bcd_q     <= '0;
      err_q     <= '0;
      valid_q   <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      dig_cnt_q <= dig_cnt_d;
      sh_q      <= sh_d;
      acc_q     <= acc_d;
      aerr_q    <= aerr_d;
      bcd_q     <= bcd_d;
      err_q     <= err_d;
      valid_q   <= state_d == HOLD;
      abort_q   <= abort_d;
    end
  end

  assign bus.in_ready    = state_q != HOLD;
  assign bus.out_valid   = valid_q;
  assign bus.out_bcd     = bcd_q;
  assign bus.out_err     = err_q;
  assign bus.frame_abort = abort_q;
endmodule
